// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: serial FSM state encoding
// and default datapath width for the sequential arithmetic blocks.
package arith_pkg;

    localparam int ARITH_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/full_adder_bit.sv
// Single-bit full adder cell, reused every cycle by the serial adder.
// Purely combinational.
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder4.sv
// Bit-serial adder: {Cout,S} = A + B + Cin, one bit per cycle, LSB first.
// Define SERIAL_ADDER4_OVF_EN to add the registered signed-overflow output Ovf.
module serial_adder4
    import arith_pkg::*;
#(
    parameter int WIDTH = ARITH_WIDTH
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] S,
    output logic             Cout
`ifdef SERIAL_ADDER4_OVF_EN
    ,
    output logic             Ovf
`endif
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             fa_s, fa_co;
`ifdef SERIAL_ADDER4_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    full_adder_bit u_fa (
        .a  (a_q[0]),
        .b  (b_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    // Next-state: accept Start in IDLE/DONE, shift one bit per SHIFT cycle
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
`ifdef SERIAL_ADDER4_OVF_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            IDLE, DONE: begin
                if (Start) begin
                    a_d     = A;
                    b_d     = B;
                    carry_d = Cin;
                    s_d     = '0;
                    cnt_d   = '0;
`ifdef SERIAL_ADDER4_OVF_EN
                    ovf_d   = 1'b0;
`endif
                    state_d = SHIFT;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                s_d     = {fa_s, s_q[WIDTH-1:1]};
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = fa_co;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
`ifdef SERIAL_ADDER4_OVF_EN
                    // carry into MSB is carry_q, carry out of MSB is fa_co
                    ovf_d   = carry_q ^ fa_co;
`endif
                    cnt_d   = cnt_q;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef SERIAL_ADDER4_OVF_EN
    // Overflow flag, captured on the final bit and held with S
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign Ovf = ovf_q;
`endif

    assign Busy = (state_q == SHIFT);
    assign Done = (state_q == DONE);
    assign S    = s_q;
    assign Cout = carry_q;

endmodule

// File: tb/tb_serial_adder4.sv
// Directed and exhaustive checks for serial_adder4.
// Honours SERIAL_ADDER4_OVF_EN for the Ovf port.
module tb_serial_adder4;

    localparam int W = 4;

    logic         Clock;
    logic         Resetn;
    logic         Start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Cin;
    logic         Busy;
    logic         Done;
    logic [W-1:0] S;
    logic         Cout;
`ifdef SERIAL_ADDER4_OVF_EN
    logic         Ovf;
`endif

    int checks;
    int errors;

    serial_adder4 #(.WIDTH(W)) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .Start  (Start),
        .A      (A),
        .B      (B),
        .Cin    (Cin),
        .Busy   (Busy),
        .Done   (Done),
        .S      (S),
        .Cout   (Cout)
`ifdef SERIAL_ADDER4_OVF_EN
        ,
        .Ovf    (Ovf)
`endif
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] s;
        logic         cout;
        logic         ovf;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Launch one operation; returns outputs seen on the Done cycle
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, output logic [W-1:0] s,
                          output logic cout, output logic ovf,
                          output int busy_n, output int lat);
        bit got;
        A = a; B = b; Cin = cin; Start = 1'b1;
        @(posedge Clock); #1;
        Start = 1'b0;
        busy_n = 0; lat = 1; got = 0;
        s = '0; cout = 1'b0; ovf = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (Done) begin
                got = 1;
                break;
            end
            if (Busy) busy_n++;
            @(posedge Clock); #1;
            lat++;
        end
        if (!got) begin
            errors++;
            checks++;
            $display("FAIL timeout waiting for Done a=%0h b=%0h", a, b);
        end
        s = S;
        cout = Cout;
`ifdef SERIAL_ADDER4_OVF_EN
        ovf = Ovf;
`endif
    endtask

    vec_t vecs[10];

    initial begin
        logic [W-1:0] rs;
        logic         rc;
        logic         ro;
        int           bn;
        int           lt;
        int           last;
        int           ndone;
        logic [W:0]   ref_sum;

        checks = 0;
        errors = 0;

        //            a      b      cin   s      cout  ovf
        vecs[0] = '{4'h5, 4'h3, 1'b0, 4'h8, 1'b0, 1'b1};
        vecs[1] = '{4'hF, 4'h1, 1'b0, 4'h0, 1'b1, 1'b0};
        vecs[2] = '{4'h0, 4'h0, 1'b1, 4'h1, 1'b0, 1'b0};
        vecs[3] = '{4'h7, 4'h1, 1'b0, 4'h8, 1'b0, 1'b1};
        vecs[4] = '{4'hF, 4'hF, 1'b0, 4'hE, 1'b1, 1'b0};
        vecs[5] = '{4'h9, 4'h6, 1'b0, 4'hF, 1'b0, 1'b0};
        vecs[6] = '{4'hA, 4'h5, 1'b1, 4'h0, 1'b1, 1'b0};
        vecs[7] = '{4'h8, 4'h8, 1'b0, 4'h0, 1'b1, 1'b1};
        vecs[8] = '{4'h3, 4'h2, 1'b1, 4'h6, 1'b0, 1'b0};
        vecs[9] = '{4'h6, 4'h9, 1'b1, 4'h0, 1'b1, 1'b0};

        Resetn = 1'b0; Start = 1'b0;
        A = '0; B = '0; Cin = 1'b0;
        repeat (3) @(posedge Clock);
        #1;
        chk("reset_busy", int'(Busy), 0);
        chk("reset_done", int'(Done), 0);
        chk("reset_s", int'(S), 0);
        chk("reset_cout", int'(Cout), 0);
`ifdef SERIAL_ADDER4_OVF_EN
        chk("reset_ovf", int'(Ovf), 0);
`endif
        Resetn = 1'b1;
        @(posedge Clock); #1;

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, rs, rc, ro, bn, lt);
            chk($sformatf("vec%0d_s", i), int'(rs), int'(vecs[i].s));
            chk($sformatf("vec%0d_cout", i), int'(rc), int'(vecs[i].cout));
`ifdef SERIAL_ADDER4_OVF_EN
            chk($sformatf("vec%0d_ovf", i), int'(ro), int'(vecs[i].ovf));
`endif
            if (i == 0) begin
                chk("busy_cycles", bn, W);
                chk("done_latency", lt, W + 1);
            end
            @(posedge Clock); #1;
            chk($sformatf("vec%0d_done_pulse", i), int'(Done), 0);
            chk($sformatf("vec%0d_s_held", i), int'(S), int'(vecs[i].s));
            chk($sformatf("vec%0d_cout_held", i), int'(Cout),
                int'(vecs[i].cout));
        end

        // Start held high: back-to-back operations, noise during SHIFT
        A = 4'h2; B = 4'h2; Cin = 1'b0; Start = 1'b1;
        last = -1; ndone = 0;
        for (int c = 0; c < 40 && ndone < 4; c++) begin
            @(posedge Clock); #1;
            if (Done) begin
                chk("b2b_s", int'(S), 4);
                chk("b2b_cout", int'(Cout), 0);
                if (last >= 0) chk("b2b_period", c - last, W + 1);
                last = c;
                ndone++;
                A = 4'h2; B = 4'h2; Cin = 1'b0;
            end else if (Busy) begin
                A = 4'($urandom);
                B = 4'($urandom);
                Cin = 1'($urandom);
            end
        end
        chk("b2b_count", ndone, 4);
        Start = 1'b0;
        A = 4'h2; B = 4'h2; Cin = 1'b0;
        repeat (W + 2) @(posedge Clock);
        #1;
        chk("b2b_idle", int'(Busy), 0);

        // Reset in the 2nd SHIFT cycle aborts with no Done
        A = 4'h9; B = 4'h6; Cin = 1'b0; Start = 1'b1;
        @(posedge Clock); #1;
        Start = 1'b0;
        @(posedge Clock); #1;
        chk("abort_busy_before", int'(Busy), 1);
        Resetn = 1'b0;
        #1;
        chk("abort_busy", int'(Busy), 0);
        chk("abort_done", int'(Done), 0);
        chk("abort_s", int'(S), 0);
        chk("abort_cout", int'(Cout), 0);
`ifdef SERIAL_ADDER4_OVF_EN
        chk("abort_ovf", int'(Ovf), 0);
`endif
        ndone = 0;
        repeat (2) begin
            @(posedge Clock); #1;
            if (Done) ndone++;
        end
        Resetn = 1'b1;
        repeat (W + 2) begin
            @(posedge Clock); #1;
            if (Done) ndone++;
        end
        chk("abort_no_done", ndone, 0);
        run_op(4'h9, 4'h6, 1'b0, rs, rc, ro, bn, lt);
        chk("after_abort_s", int'(rs), 4'hF);
        chk("after_abort_cout", int'(rc), 0);

        // Exhaustive sweep against a plain integer reference sum
        for (int x = 0; x < 512; x++) begin
            ref_sum = 5'(x[3:0]) + 5'(x[7:4]) + 5'(x[8]);
            run_op(x[3:0], x[7:4], x[8], rs, rc, ro, bn, lt);
            chk($sformatf("sweep_%0d", x), int'({rc, rs}), int'(ref_sum));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
